lsu_mem_arbiter: RTL and testbench

LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

---
 rtl/lsu_mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: two-requester round-robin front end to a single-port,
// word-wide data memory. One request is in flight at a time. Sub-word stores
// are done as read-modify-write: the word is captured in ACCESS and written
// back with the addressed lane replaced in MERGE.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arbitrate; one-hot ready toward the winner; accept + latch
// ACCESS | drive word index; loads capture lane, word stores write,
//        | sub-word stores capture the old word
// MERGE  | write captured word with the addressed lane replaced
// RESP   | response valid toward the latched requester until accepted
module lsu_mem_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [1:0]  i_req_we,
  input  logic [3:0]  i_req_size,
  input  logic [1:0]  i_req_unsigned,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        any_valid;
  logic        gnt_id;
  logic        sel_we;
  logic        sel_uns;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_illegal;

  // Memory is 256 words; anything beyond word index 255 is rejected up front.
  function automatic logic is_illegal(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    if (size == SZ_ILL) bad = 1'b1;
    if ((size == SZ_HALF) && addr[0]) bad = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) bad = 1'b1;
    if (addr[31:10] != 22'd0) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane,
                                             input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else begin
      if (lane[1]) r[31:16] = wd[15:0];
      else         r[15:0]  = wd[15:0];
    end
    return r;
  endfunction

  // Arbitration: when both are valid rr picks, otherwise the sole valid one wins.
  always_comb begin
    any_valid = |i_req_valid;
    if (&i_req_valid) gnt_id = rr_q;
    else              gnt_id = i_req_valid[1];
    sel_we      = gnt_id ? i_req_we[1]         : i_req_we[0];
    sel_uns     = gnt_id ? i_req_unsigned[1]   : i_req_unsigned[0];
    sel_size    = gnt_id ? i_req_size[3:2]     : i_req_size[1:0];
    sel_addr    = gnt_id ? i_req_addr[63:32]   : i_req_addr[31:0];
    sel_wdata   = gnt_id ? i_req_wdata[63:32]  : i_req_wdata[31:0];
    sel_illegal = is_illegal(sel_size, sel_addr);
  end

  // Next-state and output decode; every output defaults to 0 outside its state.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    o_rsp_rdata = 32'h0;
    o_rsp_err   = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_wren  = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is held low while reset is asserted even though state is IDLE.
        if (any_valid && !i_reset) begin
          o_req_ready = gnt_id ? 2'b10 : 2'b01;
          rr_d        = ~gnt_id;
          id_d        = gnt_id;
          we_d        = sel_we;
          size_d      = sel_size;
          uns_d       = sel_uns;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          word_d      = 32'h0;
          rdata_d     = 32'h0;
          err_d       = sel_illegal;
          state_d     = sel_illegal ? RESP : ACCESS;
        end
      end

      ACCESS: begin
        o_mem_addr = {2'b00, addr_q[31:2]};
        if (!we_q) begin
          rdata_d = load_extract(i_mem_rdata, size_q, addr_q[1:0], uns_q);
          state_d = RESP;
        end else if (size_q == SZ_WORD) begin
          o_mem_wren  = 1'b1;
          o_mem_wdata = wdata_q;
          state_d     = RESP;
        end else begin
          word_d  = i_mem_rdata;
          state_d = MERGE;
        end
      end

      MERGE: begin
        o_mem_addr  = {2'b00, addr_q[31:2]};
        o_mem_wren  = 1'b1;
        o_mem_wdata = lane_merge(word_q, size_q, addr_q[1:0], wdata_q);
        state_d     = RESP;
      end

      RESP: begin
        o_rsp_valid = id_q ? 2'b10 : 2'b01;
        o_rsp_rdata = rdata_q;
        o_rsp_err   = err_q;
        if (i_rsp_ready[id_q]) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and latched request fields; reset clears everything immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Testbench for lsu_mem_arbiter: directed and random transactions checked
// against a byte-addressed reference memory model.
module tb_lsu_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [1:0]  i_req_we;
  logic [3:0]  i_req_size;
  logic [1:0]  i_req_unsigned;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic [1:0]  o_rsp_valid;
  logic [1:0]  i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment memory (the DUT's data memory) with a backdoor for preload.
  logic [31:0] mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  // Reference model: plain byte array, little-endian.
  logic [7:0]  ref_bytes [0:1023];

  lsu_mem_arbiter dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_wren     (o_mem_wren),
    .i_mem_rdata    (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  assign i_mem_rdata = (o_mem_addr < 32'd256) ? mem[o_mem_addr[7:0]] : 32'h0;

  // Memory write port: backdoor preload or DUT store strobe.
  always @(posedge i_clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (o_mem_wren && (o_mem_addr < 32'd256)) mem[o_mem_addr[7:0]] <= o_mem_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // Applies one access to the reference memory and predicts the response.
  task automatic ref_apply(input bit we, input bit [1:0] size, input bit uns,
                           input bit [31:0] addr, input bit [31:0] wdata,
                           output bit err, output bit [31:0] rdata, output bit [31:0] word);
    int n;
    longint unsigned v;
    n     = 1 << size;
    err   = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'd1024);
    rdata = 32'h0;
    word  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) ref_bytes[addr + k] = 8'((wdata >> (8 * k)) & 32'hFF);
        word = ref_word(int'(addr / 4));
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v | (longint'(ref_bytes[addr + k]) << (8 * k));
        if (!uns && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
        rdata = v[31:0];
      end
    end
  endtask

  // One complete transaction from requester id; hold>0 backpressures the response.
  task automatic do_txn(input int id, input bit we, input bit [1:0] size, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wdata, input int hold,
                        output logic [31:0] obs);
    bit          e_err;
    bit [31:0]   e_rd;
    bit [31:0]   e_word;
    int          exp_lat;
    int          lat;
    int          wren_n;
    bit          got;
    ref_apply(we, size, uns, addr, wdata, e_err, e_rd, e_word);
    exp_lat = e_err ? 1 : ((we && size != 2'd2) ? 3 : 2);
    i_req_we[id]              = we;
    i_req_size[2*id +: 2]     = size;
    i_req_unsigned[id]        = uns;
    i_req_addr[32*id +: 32]   = addr;
    i_req_wdata[32*id +: 32]  = wdata;
    i_rsp_ready               = 2'b11;
    if (hold > 0) i_rsp_ready[id] = 1'b0;
    i_req_valid               = 2'b00;
    i_req_valid[id]           = 1'b1;
    #1;
    check("req_ready", 32'(o_req_ready), 32'(1 << id));
    @(posedge i_clk); #1;
    i_req_valid = 2'b00;
    got = 0; lat = 0; wren_n = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      if (c > 1) begin @(posedge i_clk); #1; end
      if (o_mem_wren) begin
        wren_n++;
        check("wren_addr", o_mem_addr, addr >> 2);
        check("wren_data", o_mem_wdata, e_word);
        check("wren_cycle", 32'(c), 32'(exp_lat - 1));
      end
      if (o_rsp_valid != 2'b00) begin got = 1; lat = c; end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("wren_count", 32'(wren_n), (!e_err && we) ? 32'd1 : 32'd0);
    check("rsp_valid", 32'(o_rsp_valid), 32'(1 << id));
    check("rsp_rdata", o_rsp_rdata, e_rd);
    check("rsp_err", 32'(o_rsp_err), 32'(e_err));
    check("resp_mem_idle", {o_mem_addr[30:0], o_mem_wren} | o_mem_wdata, 32'h0);
    obs = o_rsp_rdata;
    if (hold > 0) begin
      i_req_we[1-id]             = 1'b0;
      i_req_size[2*(1-id) +: 2]  = 2'd2;
      i_req_addr[32*(1-id) +: 32] = 32'h0;
      i_req_valid[1-id]          = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge i_clk); #1;
        check("bp_ready", 32'(o_req_ready), 32'h0);
        check("bp_valid", 32'(o_rsp_valid), 32'(1 << id));
        check("bp_rdata", o_rsp_rdata, e_rd);
        check("bp_err", 32'(o_rsp_err), 32'(e_err));
      end
      i_rsp_ready[id] = 1'b1;
      #1;
      check("exit_ready", 32'(o_req_ready), 32'h0);
      @(posedge i_clk); #1;
      check("exit_rsp", 32'(o_rsp_valid), 32'h0);
      check("idle_ready", 32'(o_req_ready), 32'(1 << (1 - id)));
      i_req_valid = 2'b00;
    end else begin
      @(posedge i_clk); #1;
      check("exit_rsp", 32'(o_rsp_valid), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] w;
    int          gnts[$];
    int          both;
    int          r_id;
    bit          r_we;
    bit          r_uns;
    bit [1:0]    r_size;
    bit [31:0]   r_addr;
    int          r_hold;
    int          bad_cyc;

    i_reset = 1'b1;
    i_req_valid = 2'b11;
    i_req_we = 2'b00; i_req_size = 4'b1010; i_req_unsigned = 2'b00;
    i_req_addr = 64'h0; i_req_wdata = 64'h0; i_rsp_ready = 2'b11;
    bd_we = 1'b0; bd_addr = 8'h0; bd_data = 32'h0;
    #1;
    check("rst_req_ready", 32'(o_req_ready), 32'h0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'h0);
    check("rst_mem_wren", 32'(o_mem_wren), 32'h0);
    check("rst_mem_addr", o_mem_addr, 32'h0);
    check("rst_mem_wdata", o_mem_wdata, 32'h0);

    // Preload memory and reference with the same random contents.
    i_req_valid = 2'b00;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      bd_we = 1'b1; bd_addr = 8'(i); bd_data = w;
      {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]} = w;
      @(posedge i_clk); #1;
    end
    bd_we = 1'b0;
    i_reset = 1'b0;

    // Word store then load back.
    do_txn(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, obs);
    do_txn(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, obs);
    check("lw_0x10", obs, 32'hDEADBEEF);

    // Sub-word read-modify-write and sign/zero extension.
    do_txn(0, 1, 2'd0, 0, 32'h12, 32'h00000055, 0, obs);
    do_txn(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, obs);
    check("lw_after_sb", obs, 32'hDE55BEEF);
    do_txn(0, 0, 2'd0, 0, 32'h13, 32'h0, 0, obs);
    check("lb_0x13", obs, 32'hFFFFFFDE);
    do_txn(1, 0, 2'd0, 1, 32'h13, 32'h0, 0, obs);
    check("lbu_0x13", obs, 32'h000000DE);
    do_txn(0, 0, 2'd1, 0, 32'h12, 32'h0, 0, obs);
    check("lh_0x12", obs, 32'hFFFFDE55);

    // Illegal accesses.
    do_txn(0, 0, 2'd2, 0, 32'h11, 32'h0, 0, obs);
    do_txn(1, 1, 2'd1, 0, 32'h03, 32'h1234, 0, obs);
    do_txn(0, 1, 2'd2, 0, 32'h400, 32'hCAFEF00D, 0, obs);
    do_txn(1, 0, 2'd3, 0, 32'h20, 32'h0, 0, obs);

    // Response backpressure with the other requester waiting.
    do_txn(1, 0, 2'd2, 0, 32'h10, 32'h0, 5, obs);
    do_txn(0, 1, 2'd1, 0, 32'h22, 32'h0000A5A5, 5, obs);

    // Reset while in MERGE: store is aborted, memory untouched.
    i_req_we[0] = 1'b1; i_req_size[1:0] = 2'd0; i_req_addr[31:0] = 32'h21;
    i_req_wdata[31:0] = 32'h000000AA; i_rsp_ready = 2'b11; i_req_valid = 2'b01;
    @(posedge i_clk); #1;
    i_req_valid = 2'b00;
    check("rmw_access_nowren", 32'(o_mem_wren), 32'h0);
    @(posedge i_clk); #1;
    check("rmw_merge_wren", 32'(o_mem_wren), 32'h1);
    i_reset = 1'b1;
    #1;
    check("mrst_wren", 32'(o_mem_wren), 32'h0);
    check("mrst_addr", o_mem_addr, 32'h0);
    check("mrst_wdata", o_mem_wdata, 32'h0);
    check("mrst_rsp", {30'h0, o_rsp_valid} | {31'h0, o_rsp_err} | o_rsp_rdata, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    check("mrst_mem_word", mem[8], ref_word(8));
    // First accept right after deassert; the load also proves the word is intact.
    do_txn(0, 0, 2'd2, 0, 32'h20, 32'h0, 0, obs);

    // Round-robin with both requesters valid continuously.
    i_reset = 1'b1; #1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_req_we = 2'b00; i_req_size = 4'b1010; i_req_unsigned = 2'b00;
    i_req_addr = {32'h14, 32'h10}; i_rsp_ready = 2'b11;
    i_req_valid = 2'b11;
    both = 0;
    for (int c = 0; c < 60 && gnts.size() < 4; c++) begin
      #1;
      if (o_req_ready == 2'b11) both++;
      if (o_req_ready != 2'b00) gnts.push_back(int'(o_req_ready[1]));
      @(posedge i_clk); #1;
    end
    i_req_valid = 2'b00;
    bad_cyc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge i_clk); #1;
      if (o_rsp_valid == 2'b00 && o_req_ready != 2'b00) bad_cyc++;
    end
    check("arb_both_ready", 32'(both), 32'h0);
    check("arb_grants", 32'(gnts.size()), 32'd4);
    for (int i = 0; i < gnts.size() && i < 4; i++) check("arb_order", 32'(gnts[i]), 32'(i % 2));
    check("arb_drain_idle", 32'(o_rsp_valid), 32'h0);
    check("arb_no_ready_idle", 32'(bad_cyc), 32'h0);

    // Random traffic against the reference model.
    for (int t = 0; t < 60; t++) begin
      r_id   = int'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      if ($urandom_range(0, 15) == 0) r_addr = r_addr + 32'h400 * 32'($urandom_range(1, 100));
      r_hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_txn(r_id, r_we, r_size, r_uns, r_addr, $urandom, r_hold, obs);
    end

    for (int i = 0; i < 256; i++) check("mem_final", mem[i], ref_word(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
